// File: rtl/cond_exec_unit.sv
// Execute-stage ID/EX register, NZCV flags register and condition-gated enables.
// Optional squash counter enabled with macro COND_EXEC_SQUASH_CNT_EN.
module cond_exec_unit #(
   parameter logic [3:0]  RESET_FLAGS = 4'b0000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallE,
   input  logic             FlushE,
   input  logic             PCSrcD,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             MemWriteD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic             NoWriteD,
   input  logic [2:0]       ALUControlD,
   input  logic [1:0]       FlagWriteD,
   input  logic [3:0]       CondD,
   input  logic [3:0]       ALUFlags,
   output logic             PCSrcE,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             MemtoRegE,
   output logic             ALUSrcE,
   output logic [2:0]       ALUControlE,
   output logic             BranchTakenE,
   output logic             CondExE,
`ifdef COND_EXEC_SQUASH_CNT_EN
   output logic [CNT_W-1:0] SquashCnt,
`endif
   output logic [3:0]       Flags
);

   localparam int unsigned ALUC_W = 3;
   localparam int unsigned FW_W   = 2;
   localparam int unsigned COND_W = 4;

   logic              valid_e;
   logic              pcsrc_e;
   logic              regwrite_e;
   logic              memtoreg_e;
   logic              memwrite_e;
   logic              branch_e;
   logic              alusrc_e;
   logic              nowrite_e;
   logic [ALUC_W-1:0] alucontrol_e;
   logic [FW_W-1:0]   flagwrite_e;
   logic [COND_W-1:0] cond_e;
   logic [3:0]        flags_q;
   logic              cond_ex;
   logic              gate;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   // ID/EX pipeline register: flush beats stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_e      <= 1'b0;
         pcsrc_e      <= 1'b0;
         regwrite_e   <= 1'b0;
         memtoreg_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         branch_e     <= 1'b0;
         alusrc_e     <= 1'b0;
         nowrite_e    <= 1'b0;
         alucontrol_e <= '0;
         flagwrite_e  <= '0;
         cond_e       <= '0;
      end else if (FlushE) begin
         valid_e      <= 1'b0;
         pcsrc_e      <= 1'b0;
         regwrite_e   <= 1'b0;
         memtoreg_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         branch_e     <= 1'b0;
         alusrc_e     <= 1'b0;
         nowrite_e    <= 1'b0;
         alucontrol_e <= '0;
         flagwrite_e  <= '0;
         cond_e       <= '0;
      end else if (!StallE) begin
         valid_e      <= 1'b1;
         pcsrc_e      <= PCSrcD;
         regwrite_e   <= RegWriteD;
         memtoreg_e   <= MemtoRegD;
         memwrite_e   <= MemWriteD;
         branch_e     <= BranchD;
         alusrc_e     <= ALUSrcD;
         nowrite_e    <= NoWriteD;
         alucontrol_e <= ALUControlD;
         flagwrite_e  <= FlagWriteD;
         cond_e       <= CondD;
      end
   end

   // Condition evaluation against the architectural {N,Z,C,V}
   always_comb begin
      cond_ex = 1'b0;
      case (cond_e)
         4'b0000: cond_ex = flags_q[2];
         4'b0001: cond_ex = !flags_q[2];
         4'b0010: cond_ex = flags_q[1];
         4'b0011: cond_ex = !flags_q[1];
         4'b0100: cond_ex = flags_q[3];
         4'b0101: cond_ex = !flags_q[3];
         4'b0110: cond_ex = flags_q[0];
         4'b0111: cond_ex = !flags_q[0];
         4'b1000: cond_ex = flags_q[1] & !flags_q[2];
         4'b1001: cond_ex = !flags_q[1] | flags_q[2];
         4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
         4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
         4'b1100: cond_ex = !flags_q[2] & (flags_q[3] == flags_q[0]);
         4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign gate = valid_e & cond_ex;

   // Flags halves update independently; a held instruction rewrites identical values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= RESET_FLAGS;
      end else if (gate) begin
         if (flagwrite_e[1]) flags_q[3:2] <= ALUFlags[3:2];
         if (flagwrite_e[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

`ifdef COND_EXEC_SQUASH_CNT_EN
   logic [CNT_W-1:0] squash_cnt;

   // Counts a squashed instruction once, on its last (unstalled) execute cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         squash_cnt <= '0;
      end else if (valid_e && !cond_ex && !StallE) begin
         squash_cnt <= squash_cnt + CNT_W'(1);
      end
   end

   assign SquashCnt = squash_cnt;
`endif

   assign CondExE      = cond_ex;
   assign PCSrcE       = pcsrc_e & gate;
   assign RegWriteE    = regwrite_e & gate & !nowrite_e;
   assign MemWriteE    = memwrite_e & gate;
   assign BranchTakenE = branch_e & gate;
   assign MemtoRegE    = memtoreg_e;
   assign ALUSrcE      = alusrc_e;
   assign ALUControlE  = alucontrol_e;
   assign Flags        = flags_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit (squash counter tests under COND_EXEC_SQUASH_CNT_EN).
module tb_cond_exec_unit;

   logic       clk;
   logic       reset;
   logic       StallE, FlushE;
   logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD;
   logic [2:0] ALUControlD;
   logic [1:0] FlagWriteD;
   logic [3:0] CondD;
   logic [3:0] ALUFlags;
   logic       PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE, CondExE;
   logic [2:0] ALUControlE;
   logic [3:0] Flags;
`ifdef COND_EXEC_SQUASH_CNT_EN
   logic [15:0] SquashCnt;
`endif

   int checks   = 0;
   int failures = 0;

   cond_exec_unit dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
      .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
      .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
      .NoWriteD(NoWriteD), .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD),
      .CondD(CondD), .ALUFlags(ALUFlags),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .BranchTakenE(BranchTakenE), .CondExE(CondExE),
`ifdef COND_EXEC_SQUASH_CNT_EN
      .SquashCnt(SquashCnt),
`endif
      .Flags(Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      PCSrcD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0;
      ALUSrcD = 0; NoWriteD = 0; ALUControlD = 3'b000; FlagWriteD = 2'b00; CondD = 4'b1110;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #3 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [4:0] gated;
      checks++;
      if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
      // drive Flags to 1111 and leave a valid AL RegWrite/MemWrite/Branch in execute
      clear_d(); FlagWriteD = 2'b11; step();
      ALUFlags = 4'b1111; clear_d(); RegWriteD = 1; MemWriteD = 1; PCSrcD = 1; BranchD = 1; step();
      checks++;
      if (Flags !== 4'b1111) begin failures++; $display("FAIL preset_flags got=%b exp=1111", Flags); end
      gated = {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE};
      checks++;
      if (gated !== 5'b11111) begin failures++; $display("FAIL pre_reset_gated got=%b exp=11111", gated); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin failures++; $display("FAIL async_reset_flags got=%b exp=0000", Flags); end
      gated = {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, 1'b0};
      checks++;
      if (gated !== 5'b00000) begin failures++; $display("FAIL async_reset_gated got=%b exp=00000", gated); end
      clear_d();
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cmp_beq();
      clear_d(); FlagWriteD = 2'b11; step();
      ALUFlags = 4'b0110; clear_d(); BranchD = 1; PCSrcD = 1; CondD = 4'b0000; step();
      checks++;
      if (Flags !== 4'b0110) begin failures++; $display("FAIL cmp_flags got=%b exp=0110", Flags); end
      checks++;
      if ({BranchTakenE, PCSrcE, CondExE} !== 3'b111)
         begin failures++; $display("FAIL beq_taken got=%b exp=111", {BranchTakenE, PCSrcE, CondExE}); end
      clear_d(); step();
   endtask

   task automatic test_cond_fail();
      clear_d(); FlagWriteD = 2'b11; step();
      ALUFlags = 4'b0100;
      clear_d(); RegWriteD = 1; MemWriteD = 1; FlagWriteD = 2'b11; CondD = 4'b0001;
      MemtoRegD = 1; ALUSrcD = 1; ALUControlD = 3'b101; step();
      ALUFlags = 4'b1011; clear_d();
      checks++;
      if ({CondExE, RegWriteE, MemWriteE} !== 3'b000)
         begin failures++; $display("FAIL ne_squash got=%b exp=000", {CondExE, RegWriteE, MemWriteE}); end
      checks++;
      if ({MemtoRegE, ALUSrcE, ALUControlE} !== 5'b11101)
         begin failures++; $display("FAIL squash_passthru got=%b exp=11101", {MemtoRegE, ALUSrcE, ALUControlE}); end
      step();
      checks++;
      if (Flags !== 4'b0100) begin failures++; $display("FAIL squash_flags got=%b exp=0100", Flags); end
   endtask

   task automatic test_flush_stall();
      clear_d(); RegWriteD = 1; StallE = 1; FlushE = 1; step();
      StallE = 0; FlushE = 0;
      checks++;
      if ({RegWriteE, PCSrcE, MemWriteE} !== 3'b000)
         begin failures++; $display("FAIL flush_bubble got=%b exp=000", {RegWriteE, PCSrcE, MemWriteE}); end
      clear_d(); RegWriteD = 1; ALUControlD = 3'b010; step();
      checks++;
      if ({RegWriteE, ALUControlE} !== 4'b1010)
         begin failures++; $display("FAIL capture got=%b exp=1010", {RegWriteE, ALUControlE}); end
      StallE = 1; ALUControlD = 3'b111; RegWriteD = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({RegWriteE, ALUControlE} !== 4'b1010)
            begin failures++; $display("FAIL stall_hold[%0d] got=%b exp=1010", i, {RegWriteE, ALUControlE}); end
      end
      StallE = 0; step();
      checks++;
      if (ALUControlE !== 3'b111) begin failures++; $display("FAIL stall_release got=%b exp=111", ALUControlE); end
      clear_d(); step();
   endtask

   task automatic test_partial_nowrite();
      logic [15:0] exp_tab;
      clear_d(); FlagWriteD = 2'b11; step();
      ALUFlags = 4'b0000; clear_d(); FlagWriteD = 2'b01; step();
      checks++;
      if (Flags !== 4'b0000) begin failures++; $display("FAIL clear_flags got=%b exp=0000", Flags); end
      ALUFlags = 4'b1111; clear_d(); CondD = 4'b1111; RegWriteD = 1; step();
      checks++;
      if (Flags !== 4'b0011) begin failures++; $display("FAIL partial_flags got=%b exp=0011", Flags); end
      checks++;
      if ({CondExE, RegWriteE} !== 2'b00)
         begin failures++; $display("FAIL never_cond got=%b exp=00", {CondExE, RegWriteE}); end
      clear_d(); RegWriteD = 1; NoWriteD = 1; step();
      checks++;
      if ({CondExE, RegWriteE} !== 2'b10)
         begin failures++; $display("FAIL nowrite got=%b exp=10", {CondExE, RegWriteE}); end
      // N=0 Z=0 C=1 V=1: expected CondExE per code, bit c = result of condition c
      exp_tab = 16'h6966;
      for (int c = 0; c < 16; c++) begin
         clear_d(); CondD = 4'(c); step();
         checks++;
         if (CondExE !== exp_tab[c])
            begin failures++; $display("FAIL cond_table[%0d] got=%b exp=%b", c, CondExE, exp_tab[c]); end
      end
      clear_d(); step();
   endtask

`ifdef COND_EXEC_SQUASH_CNT_EN
   task automatic test_squash_cnt();
      do_reset();
      checks++;
      if (SquashCnt !== 16'd0) begin failures++; $display("FAIL cnt_reset got=%h exp=0000", SquashCnt); end
      clear_d(); CondD = 4'b0000; step();
      step();
      StallE = 1; step(); step();
      StallE = 0; step();
      clear_d(); step();
      checks++;
      if (SquashCnt !== 16'd3) begin failures++; $display("FAIL cnt_three got=%h exp=0003", SquashCnt); end
      clear_d(); CondD = 4'b0000; step();
      for (int i = 0; i < 65532; i++) step();
      checks++;
      if (SquashCnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_max got=%h exp=ffff", SquashCnt); end
      step();
      checks++;
      if (SquashCnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", SquashCnt); end
      clear_d(); step();
   endtask
`endif

   initial begin
      reset = 1'b1; StallE = 0; FlushE = 0; ALUFlags = 4'b0000;
      clear_d();
      #12 reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_cmp_beq();
      test_cond_fail();
      test_flush_stall();
      test_partial_nowrite();
`ifdef COND_EXEC_SQUASH_CNT_EN
      test_squash_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
